lane_width_byte_striper: RTL and testbench

// - Stripes a 4-byte (DW) symbol stream across a runtime-selectable PCIe link width, x1..x(MAX_LANES).
// - Serialises each DW over several beats for x1/x2, passes x4 through, gathers several DWs per beat for x8/x16.
// - Pads a short final stripe with PAD K-symbols; valid/ready on both sides.
// - Sits between the TLP/DLLP framer and per-lane scramblers/encoders.

---
 rtl/lane_width_byte_striper_if.sv | 36 +++
 rtl/lane_width_byte_striper.sv | 209 ++++++++++++++++++++
 tb/tb_lane_width_byte_striper.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_width_byte_striper_if.sv
// ---------------------------------------------------------------------------
// lane_width_byte_striper_if
// Purpose : bundles the DW input stream and the lane stripe output stream of
//           lane_width_byte_striper into one interface.
// Signals : i_width_sel   - log2 link width request (0=x1 .. 4=x16)
//           i_valid/o_ready, i_data, i_d_k, i_last - DW input handshake
//           o_valid/i_ready, o_lane_byte, o_lane_d_k - stripe output handshake
//           o_active_mask - lanes in use for the latched width
// Modports: slave  - the striper itself
//           master - the framer/encoder side driving and sinking it
// ---------------------------------------------------------------------------
interface lane_width_byte_striper_if #(
  parameter int MAX_LANES = 16
);
  logic [2:0]             i_width_sel;
  logic                   i_valid;
  logic                   o_ready;
  logic [31:0]            i_data;
  logic [3:0]             i_d_k;
  logic                   i_last;
  logic                   o_valid;
  logic                   i_ready;
  logic [8*MAX_LANES-1:0] o_lane_byte;
  logic [MAX_LANES-1:0]   o_lane_d_k;
  logic [MAX_LANES-1:0]   o_active_mask;

  modport slave (
    input  i_width_sel, i_valid, i_data, i_d_k, i_last, i_ready,
    output o_ready, o_valid, o_lane_byte, o_lane_d_k, o_active_mask
  );

  modport master (
    output i_width_sel, i_valid, i_data, i_d_k, i_last, i_ready,
    input  o_ready, o_valid, o_lane_byte, o_lane_d_k, o_active_mask
  );
endinterface

// File: rtl/lane_width_byte_striper.sv
// ---------------------------------------------------------------------------
// lane_width_byte_striper
// Purpose : stripes a 4-byte symbol stream across a runtime-selectable link
//           width. x1/x2 serialise each DW over several beats, x4 passes
//           straight through, x8/x16 gather several DWs per beat. A stripe
//           closed early by i_last is padded with PAD_SYM K-symbols.
// Ports   : i_clk  - clock
//           i_rst  - asynchronous reset, active-high
//           io_bus - lane_width_byte_striper_if.slave (input DW stream,
//                    output stripe stream, width select, active lane mask)
// ---------------------------------------------------------------------------
module lane_width_byte_striper #(
  parameter int         MAX_LANES = 16,
  parameter logic [7:0] PAD_SYM   = 8'hF7
) (
  input logic                       i_clk,
  input logic                       i_rst,
  lane_width_byte_striper_if.slave  io_bus
);

  localparam int         LW       = 8 * MAX_LANES;
  localparam logic [2:0] MAX_LOG2 = 3'($clog2(MAX_LANES));

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SPLIT  = 2'd1;
  localparam logic [1:0] ST_GATHER = 2'd2;

  logic [2:0]           r_width_q;
  logic [4:0]           r_ptr;
  logic [2:0]           r_split_cnt;
  logic [1:0]           r_split_idx;
  logic [31:0]          r_hold_data;
  logic [3:0]           r_hold_k;
  logic [LW-1:0]        r_gath_byte;
  logic [MAX_LANES-1:0] r_gath_k;
  logic                 r_full;
  logic [LW-1:0]        r_out_byte;
  logic [MAX_LANES-1:0] r_out_k;
  logic                 r_out_valid;

  logic [4:0]           w_width;
  logic [2:0]           w_sel_clamped;
  logic [1:0]           w_state;
  logic                 w_is_split;
  logic                 w_is_pass;
  logic                 w_is_gather;
  logic                 w_out_load;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_close;
  logic [1:0]           w_b;
  logic [31:0]          w_hold_sh;
  logic [3:0]           w_hold_k_sh;
  logic [LW-1:0]        w_slice_byte;
  logic [MAX_LANES-1:0] w_slice_k;
  logic [LW-1:0]        w_gath_byte_nxt;
  logic [MAX_LANES-1:0] w_gath_k_nxt;
  logic [LW-1:0]        w_out_byte_nxt;
  logic [MAX_LANES-1:0] w_out_k_nxt;
  logic                 w_out_valid_nxt;
  logic [MAX_LANES-1:0] w_mask;

  assign w_width       = 5'd1 << r_width_q;
  assign w_sel_clamped = (io_bus.i_width_sel > MAX_LOG2) ? MAX_LOG2 : io_bus.i_width_sel;
  assign w_is_split    = (r_width_q < 3'd2);
  assign w_is_pass     = (r_width_q == 3'd2);
  assign w_is_gather   = (r_width_q > 3'd2);

  // A full gathered stripe is already closed (ptr back at 0), so it does
  // not block a width change; only partial stripes and pending slices do.
  assign w_state = (r_split_cnt != 3'd0) ? ST_SPLIT :
                   (r_ptr != 5'd0)       ? ST_GATHER : ST_IDLE;

  assign w_out_load = !r_out_valid || io_bus.i_ready;
  assign w_close    = ((r_ptr + 5'd4) == w_width) || io_bus.i_last;
  assign w_accept   = io_bus.i_valid && w_ready;

  // In split mode the hold register may be refilled in the same cycle its
  // last slice moves out, which keeps x1/x2 at full line rate.
  always_comb begin
    w_ready = 1'b0;
    if (w_is_gather)
      w_ready = !(r_full && r_out_valid && !io_bus.i_ready);
    else if (r_full)
      w_ready = 1'b0;
    else if (w_is_pass)
      w_ready = w_out_load;
    else
      w_ready = (w_state != ST_SPLIT) || ((r_split_cnt == 3'd1) && w_out_load);
  end

  // Current slice of the held DW, placed on lanes 0..W-1.
  always_comb begin
    w_hold_sh    = r_hold_data >> {r_split_idx, 3'b000};
    w_hold_k_sh  = r_hold_k >> r_split_idx;
    w_slice_byte = '0;
    w_slice_k    = '0;
    for (int l = 0; l < 4; l++) begin
      if (l < int'(w_width)) begin
        w_slice_byte[8*l +: 8] = w_hold_sh[8*l +: 8];
        w_slice_k[l]           = w_hold_k_sh[l];
      end
    end
  end

  // Gather buffer update for an accepted DW. Lanes beyond the width are
  // forced to zero here so the stripe can be moved out without masking.
  always_comb begin
    w_gath_byte_nxt = r_gath_byte;
    w_gath_k_nxt    = r_gath_k;
    w_b             = 2'd0;
    for (int l = 0; l < MAX_LANES; l++) begin
      if (l >= int'(w_width)) begin
        w_gath_byte_nxt[8*l +: 8] = 8'h00;
        w_gath_k_nxt[l]           = 1'b0;
      end else if ((l >= int'(r_ptr)) && (l < int'(r_ptr) + 4)) begin
        w_b                       = 2'(l - int'(r_ptr));
        w_gath_byte_nxt[8*l +: 8] = io_bus.i_data[8*w_b +: 8];
        w_gath_k_nxt[l]           = io_bus.i_d_k[w_b];
      end else if (io_bus.i_last && (l >= int'(r_ptr) + 4)) begin
        w_gath_byte_nxt[8*l +: 8] = PAD_SYM;
        w_gath_k_nxt[l]           = 1'b1;
      end
    end
  end

  // Output register source: a waiting gathered stripe first, then a pending
  // slice, then an x4 pass-through DW.
  always_comb begin
    w_out_byte_nxt  = '0;
    w_out_k_nxt     = '0;
    w_out_valid_nxt = 1'b0;
    if (r_full) begin
      w_out_byte_nxt  = r_gath_byte;
      w_out_k_nxt     = r_gath_k;
      w_out_valid_nxt = 1'b1;
    end else if (w_state == ST_SPLIT) begin
      w_out_byte_nxt  = w_slice_byte;
      w_out_k_nxt     = w_slice_k;
      w_out_valid_nxt = 1'b1;
    end else if (w_accept && w_is_pass) begin
      w_out_byte_nxt[31:0] = io_bus.i_data;
      w_out_k_nxt[3:0]     = io_bus.i_d_k;
      w_out_valid_nxt      = 1'b1;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int l = 0; l < MAX_LANES; l++)
      w_mask[l] = (l < int'(w_width));
  end

  // Later assignments override earlier ones: a refill of the hold register
  // or a new stripe close wins over the drain of the previous one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_width_q   <= 3'd0;
      r_ptr       <= 5'd0;
      r_split_cnt <= 3'd0;
      r_split_idx <= 2'd0;
      r_hold_data <= '0;
      r_hold_k    <= '0;
      r_gath_byte <= '0;
      r_gath_k    <= '0;
      r_full      <= 1'b0;
      r_out_byte  <= '0;
      r_out_k     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_out_load) begin
        r_out_byte  <= w_out_byte_nxt;
        r_out_k     <= w_out_k_nxt;
        r_out_valid <= w_out_valid_nxt;
      end
      if (w_out_load && r_full)
        r_full <= 1'b0;
      if (w_out_load && !r_full && (w_state == ST_SPLIT)) begin
        r_split_cnt <= r_split_cnt - 3'd1;
        r_split_idx <= r_split_idx + 2'(w_width);
      end
      if (w_accept && w_is_split) begin
        r_hold_data <= io_bus.i_data;
        r_hold_k    <= io_bus.i_d_k;
        r_split_cnt <= 3'd4 >> r_width_q;
        r_split_idx <= 2'd0;
      end
      if (w_accept && w_is_gather) begin
        r_gath_byte <= w_gath_byte_nxt;
        r_gath_k    <= w_gath_k_nxt;
        if (w_close) begin
          r_full <= 1'b1;
          r_ptr  <= 5'd0;
        end else begin
          r_ptr <= r_ptr + 5'd4;
        end
      end
      if ((w_state == ST_IDLE) && !w_accept)
        r_width_q <= w_sel_clamped;
    end
  end

  assign io_bus.o_ready       = w_ready;
  assign io_bus.o_valid       = r_out_valid;
  assign io_bus.o_lane_byte   = r_out_byte;
  assign io_bus.o_lane_d_k    = r_out_k;
  assign io_bus.o_active_mask = w_mask;

endmodule

// File: tb/tb_lane_width_byte_striper.sv
// ---------------------------------------------------------------------------
// tb_lane_width_byte_striper
// Purpose : self-checking bench for lane_width_byte_striper. Stripes are
//           predicted from the accepted DW sequence with a byte-queue model
//           and compared as they leave the DUT.
// ---------------------------------------------------------------------------
module tb_lane_width_byte_striper;

  localparam int ML = 16;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  k;
    logic        last;
  } dw_t;

  typedef struct {
    logic [8*ML-1:0] bytes;
    logic [ML-1:0]   k;
  } stripe_t;

  logic clk = 1'b0;
  logic rst;

  lane_width_byte_striper_if #(.MAX_LANES(ML)) bus ();

  lane_width_byte_striper #(.MAX_LANES(ML), .PAD_SYM(8'hF7)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFails   = 0;

  dw_t        srcQ[$];
  stripe_t    expQ[$];
  logic [7:0] pendB[$];
  logic       pendK[$];

  int         mW         = 0;
  logic [2:0] widthSel   = 3'd0;
  bit         forceReady = 1'b1;
  bit         readyVal   = 1'b1;
  int         readyPct   = 100;
  int         validPct   = 100;

  bit              stallPrev = 1'b0;
  logic [8*ML-1:0] prevBytes;
  logic [ML-1:0]   prevK;
  logic            lastReady;
  logic            lastValid;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ML-1:0] maskFor(input int w);
    logic [ML-1:0] m;
    m = '0;
    for (int l = 0; l < (1 << w); l++) m[l] = 1'b1;
    return m;
  endfunction

  // Reference model: the stripes one accepted DW implies at the model width.
  task automatic modelAccept(input dw_t d);
    stripe_t s;
    int      w;
    w = 1 << mW;
    if (w < 4) begin
      for (int sl = 0; sl < 4 / w; sl++) begin
        s.bytes = '0;
        s.k     = '0;
        for (int l = 0; l < w; l++) begin
          s.bytes[8*l +: 8] = d.data[8*(sl*w + l) +: 8];
          s.k[l]            = d.k[sl*w + l];
        end
        expQ.push_back(s);
      end
    end else if (w == 4) begin
      s.bytes       = '0;
      s.k           = '0;
      s.bytes[31:0] = d.data;
      s.k[3:0]      = d.k;
      expQ.push_back(s);
    end else begin
      for (int b = 0; b < 4; b++) begin
        pendB.push_back(d.data[8*b +: 8]);
        pendK.push_back(d.k[b]);
      end
      if (pendB.size() == w || d.last) begin
        s.bytes = '0;
        s.k     = '0;
        for (int l = 0; l < w; l++) begin
          if (l < pendB.size()) begin
            s.bytes[8*l +: 8] = pendB[l];
            s.k[l]            = pendK[l];
          end else begin
            s.bytes[8*l +: 8] = 8'hF7;
            s.k[l]            = 1'b1;
          end
        end
        expQ.push_back(s);
        pendB.delete();
        pendK.delete();
      end
    end
  endtask

  // One clock cycle: drive at edge+1, sample at edge+2, end at next edge+1.
  task automatic applyStimulus();
    stripe_t e;
    dw_t     d;
    if (srcQ.size() > 0 && $urandom_range(99) < validPct) begin
      bus.i_valid = 1'b1;
      bus.i_data  = srcQ[0].data;
      bus.i_d_k   = srcQ[0].k;
      bus.i_last  = srcQ[0].last;
    end else begin
      bus.i_valid = 1'b0;
      bus.i_data  = $urandom;
      bus.i_d_k   = 4'($urandom_range(15));
      bus.i_last  = 1'($urandom_range(1));
    end
    bus.i_ready     = forceReady ? readyVal : ($urandom_range(99) < readyPct);
    bus.i_width_sel = widthSel;
    #1;
    if (stallPrev) begin
      checkOutput("hold_valid", 128'(bus.o_valid), 128'(1));
      checkOutput("hold_bytes", bus.o_lane_byte, prevBytes);
      checkOutput("hold_k", 128'(bus.o_lane_d_k), 128'(prevK));
    end
    if (bus.o_valid && bus.i_ready) begin
      checkOutput("stripe_expected", 128'(expQ.size() > 0), 128'(1));
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("stripe_bytes", bus.o_lane_byte, e.bytes);
        checkOutput("stripe_k", 128'(bus.o_lane_d_k), 128'(e.k));
      end
    end
    stallPrev = bus.o_valid && !bus.i_ready;
    prevBytes = bus.o_lane_byte;
    prevK     = bus.o_lane_d_k;
    lastReady = bus.o_ready;
    lastValid = bus.o_valid;
    if (bus.i_valid && bus.o_ready) begin
      d = srcQ.pop_front();
      modelAccept(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runUntilIdle(input string tag, input int maxCycles);
    int n;
    n = 0;
    while ((srcQ.size() > 0 || expQ.size() > 0) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, 128'(srcQ.size() + expQ.size()), 128'(0));
  endtask

  task automatic setWidth(input logic [2:0] sel);
    widthSel   = sel;
    mW         = (sel > 3'd4) ? 4 : int'(sel);
    forceReady = 1'b1;
    readyVal   = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("active_mask", 128'(bus.o_active_mask), 128'(maskFor(mW)));
  endtask

  task automatic pushDw(input logic [31:0] data, input logic [3:0] k, input logic last);
    dw_t d;
    d.data = data;
    d.k    = k;
    d.last = last;
    srcQ.push_back(d);
  endtask

  task automatic pushRandomPackets(input int n);
    int len;
    for (int p = 0; p < n; p++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        pushDw($urandom, 4'($urandom_range(15)), (i == len - 1));
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lows;
    int valids;
    logic [2:0] sels [6];

    rst             = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_data      = '0;
    bus.i_d_k       = '0;
    bus.i_last      = 1'b0;
    bus.i_ready     = 1'b1;
    bus.i_width_sel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_valid", 128'(bus.o_valid), 128'(0));
    checkOutput("rst_bytes", bus.o_lane_byte, 128'(0));
    checkOutput("rst_k", 128'(bus.o_lane_d_k), 128'(0));
    checkOutput("rst_ready", 128'(bus.o_ready), 128'(1));
    checkOutput("rst_mask", 128'(bus.o_active_mask), 128'(1));
    rst = 1'b0;

    $display("[TB] x4 pass-through");
    setWidth(3'd2);
    pushDw(32'h44332211, 4'b0001, 1'b0);
    applyStimulus();
    checkOutput("x4_accepted", 128'(srcQ.size()), 128'(0));
    checkOutput("x4_latency", 128'(bus.o_valid), 128'(1));
    checkOutput("x4_lanes", bus.o_lane_byte, 128'h44332211);
    checkOutput("x4_k", 128'(bus.o_lane_d_k), 128'(1));
    runUntilIdle("x4_drain", 20);

    $display("[TB] x1 split");
    setWidth(3'd0);
    pushDw(32'hDDCCBBAA, 4'b0000, 1'b0);
    applyStimulus();
    checkOutput("x1_accepted", 128'(srcQ.size()), 128'(0));
    lows   = 0;
    valids = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      if (c < 4 && !lastReady) lows++;
      if (lastValid) valids++;
    end
    checkOutput("x1_ready_low", 128'(lows), 128'(3));
    checkOutput("x1_valid_run", 128'(valids), 128'(4));
    runUntilIdle("x1_drain", 20);

    $display("[TB] x16 gather");
    setWidth(3'd4);
    pushDw(32'h03020100, 4'h0, 1'b0);
    pushDw(32'h07060504, 4'h0, 1'b0);
    pushDw(32'h0B0A0908, 4'h0, 1'b0);
    pushDw(32'h0F0E0D0C, 4'h0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus();
      checkOutput("x16_early_valid", 128'(lastValid), 128'(0));
    end
    checkOutput("x16_sent", 128'(srcQ.size()), 128'(0));
    runUntilIdle("x16_drain", 10);

    $display("[TB] x16 short packet");
    pushDw(32'h11223344, 4'h1, 1'b0);
    pushDw(32'h55667788, 4'h0, 1'b1);
    runUntilIdle("x16_short_drain", 20);

    $display("[TB] x8 backpressure");
    setWidth(3'd3);
    forceReady = 1'b1;
    readyVal   = 1'b0;
    for (int i = 0; i < 4; i++) pushDw(32'hA0A1A2A3 + 32'(i * 32'h01010101), 4'(i), 1'b0);
    lows = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      if (!lastReady) lows++;
    end
    checkOutput("bp_ready_low", 128'(lows), 128'(1));
    checkOutput("bp_all_taken", 128'(srcQ.size()), 128'(0));
    readyVal = 1'b1;
    runUntilIdle("bp_drain", 20);

    $display("[TB] width change mid x16 stripe");
    setWidth(3'd4);
    pushDw(32'h33221100, 4'h0, 1'b0);
    pushDw(32'h77665544, 4'h2, 1'b0);
    runUntilIdle("wchg_first_half", 10);
    widthSel = 3'd2;
    pushDw(32'hBBAA9988, 4'h0, 1'b0);
    pushDw(32'hFFEEDDCC, 4'h8, 1'b0);
    checkOutput("wchg_mask_mid", 128'(bus.o_active_mask), 128'(16'hFFFF));
    applyStimulus();
    applyStimulus();
    checkOutput("wchg_mask_hold", 128'(bus.o_active_mask), 128'(16'hFFFF));
    runUntilIdle("wchg_drain", 20);
    setWidth(3'd2);
    pushDw(32'hCAFEF00D, 4'h4, 1'b0);
    runUntilIdle("wchg_x4_drain", 20);

    $display("[TB] reset mid x1 split");
    setWidth(3'd0);
    pushDw(32'h12345678, 4'hF, 1'b0);
    repeat (3) applyStimulus();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 128'(bus.o_valid), 128'(0));
    checkOutput("midrst_bytes", bus.o_lane_byte, 128'(0));
    checkOutput("midrst_k", 128'(bus.o_lane_d_k), 128'(0));
    checkOutput("midrst_ready", 128'(bus.o_ready), 128'(1));
    expQ.delete();
    srcQ.delete();
    pendB.delete();
    pendK.delete();
    stallPrev = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    valids = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus();
      if (lastValid) valids++;
    end
    checkOutput("postrst_quiet", 128'(valids), 128'(0));

    $display("[TB] randomized traffic");
    sels = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    for (int s = 0; s < 6; s++) begin
      setWidth(sels[s]);
      forceReady = 1'b0;
      readyPct   = 60;
      validPct   = 70;
      pushRandomPackets(6);
      runUntilIdle("rand_drain", 3000);
      validPct   = 100;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
